// File: rtl/mb32_rr_sched.sv
// Round-robin scheduler that time-shares one mb32_td multiplier pipeline
// between NREQ requesters and routes each product back with its requester ID.
module mb32_rr_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*WIDTH-1:0]         req_mx,
    input  logic [NREQ*WIDTH-1:0]         req_my,
    output logic [NREQ-1:0]               req_ready,
    output logic [WIDTH-1:0]              mul_mx,
    output logic [WIDTH-1:0]              mul_my,
    input  logic [2*WIDTH-1:0]            mul_product,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [2*WIDTH-1:0]            rsp_product,
    output logic [$clog2(LAT+3)-1:0]      inflight,
    output logic                          idle
);

    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned INFW = $clog2(LAT + 3);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] sel_mx;
    logic [WIDTH-1:0] sel_my;

    // Tag pipe: stage k holds the issue made k+1 edges ago; stage LAT lines up with mul_product.
    logic [LAT:0]     tag_vld;
    logic [IDW-1:0]   tag_id [LAT+1];

    // Rotating-priority search starting one past the last winner; selects winner's operands.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
        sel_mx = req_mx[32'(gnt_idx)*WIDTH +: WIDTH];
        sel_my = req_my[32'(gnt_idx)*WIDTH +: WIDTH];
    end

    // Pointer and multiplier operand registers; operands hold when nothing is granted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr    <= IDW'(NREQ - 1);
            mul_mx <= '0;
            mul_my <= '0;
        end else if (gnt_any) begin
            ptr    <= gnt_idx;
            mul_mx <= sel_mx;
            mul_my <= sel_my;
        end
    end

    // Tag pipe shifting issue valid/ID alongside the multiplier latency.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_vld <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[LAT-1:0], gnt_any};
            tag_id[0] <= gnt_idx;
            for (int unsigned i = 1; i <= LAT; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Response register: capture product and ID only when the tag says it is real.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            rsp_valid <= tag_vld[LAT];
            if (tag_vld[LAT]) begin
                rsp_id      <= tag_id[LAT];
                rsp_product <= mul_product;
            end
        end
    end

    // Outstanding-issue counter: up on issue, down as a response is launched.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inflight <= '0;
        end else if (gnt_any && !tag_vld[LAT]) begin
            inflight <= inflight + INFW'(1);
        end else if (!gnt_any && tag_vld[LAT]) begin
            inflight <= inflight - INFW'(1);
        end
    end

    // Idle reflects current requests and outstanding work.
    assign idle = (req_valid == '0) && (inflight == '0);

endmodule

// File: tb/tb_mb32_rr_sched.sv
// Directed bench for mb32_rr_sched with a behavioural mb32_td model and a response scoreboard.
module tb_mb32_rr_sched;

    localparam int unsigned W    = 32;
    localparam int unsigned N    = 4;
    localparam int unsigned L    = 2;
    localparam int unsigned IDW  = 2;
    localparam int unsigned PW   = 64;
    localparam int unsigned INFW = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_mx;
    logic [N*W-1:0]    req_my;
    logic [N-1:0]      req_ready;
    logic [W-1:0]      mul_mx;
    logic [W-1:0]      mul_my;
    logic [PW-1:0]     mul_product;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_product;
    logic [INFW-1:0]   inflight;
    logic              idle;

    always #5 CLK = ~CLK;

    mb32_rr_sched #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_mx      (req_mx),
        .req_my      (req_my),
        .req_ready   (req_ready),
        .mul_mx      (mul_mx),
        .mul_my      (mul_my),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .inflight    (inflight),
        .idle        (idle)
    );

    // Behavioural multiplier: product visible L edges after the operands change.
    logic [PW-1:0] mpipe [L];
    always @(posedge CLK) begin
        mpipe[0] <= PW'(mul_mx) * PW'(mul_my);
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_product = mpipe[L-1];

    typedef struct {
        logic [IDW-1:0] id;
        logic [PW-1:0]  prod;
        int             due;
    } exp_t;

    exp_t           sb[$];
    int             npass = 0;
    int             nfail = 0;
    int             ntot  = 0;
    int             edge_n = 0;
    int             last_gid;
    logic [N-1:0]   last_ready;
    logic [IDW-1:0] mptr;
    logic [W-1:0]   exp_mx;
    logic [W-1:0]   exp_my;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] mx, input logic [W-1:0] my);
        req_valid[i]       = v;
        req_mx[i*W +: W]   = mx;
        req_my[i*W +: W]   = my;
    endtask

    // One clock cycle: predict grant before the edge, check responses after it.
    task automatic step();
        logic [N-1:0] eready;
        int           gid;
        int           c;
        logic         erv;
        exp_t         e;
        #1;
        eready = '0;
        gid    = -1;
        for (int k = 1; k <= N; k++) begin
            c = (int'(mptr) + k) % N;
            if (gid < 0 && req_valid[c]) gid = c;
        end
        if (gid >= 0) eready[gid] = 1'b1;
        last_ready = req_ready;
        last_gid   = gid;
        chk("req_ready", PW'(req_ready), PW'(eready));
        chk("idle", PW'(idle), PW'(req_valid == '0 && sb.size() == 0));
        if (gid >= 0) begin
            exp_mx = req_mx[gid*W +: W];
            exp_my = req_my[gid*W +: W];
            e.id   = IDW'(gid);
            e.prod = PW'(exp_mx) * PW'(exp_my);
            e.due  = edge_n + int'(L) + 2;
            sb.push_back(e);
            mptr = IDW'(gid);
        end
        @(posedge CLK);
        edge_n++;
        #1;
        erv = (sb.size() > 0) && (sb[0].due == edge_n);
        chk("rsp_valid", PW'(rsp_valid), PW'(erv));
        if (erv) begin
            chk("rsp_id", PW'(rsp_id), PW'(sb[0].id));
            chk("rsp_product", rsp_product, sb[0].prod);
            void'(sb.pop_front());
        end
        chk("inflight", PW'(inflight), PW'(sb.size()));
        chk("mul_mx", PW'(mul_mx), PW'(exp_mx));
        chk("mul_my", PW'(mul_my), PW'(exp_my));
        @(negedge CLK);
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        RST       = 1'b0;
        req_valid = '0;
        #1;
        sb.delete();
        mptr   = IDW'(N - 1);
        exp_mx = '0;
        exp_my = '0;
        @(posedge CLK);
        edge_n++;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        RST       = 1'b0;
        req_valid = '0;
        req_mx    = '0;
        req_my    = '0;
        mptr      = IDW'(N - 1);
        exp_mx    = '0;
        exp_my    = '0;
        last_gid  = -1;
        last_ready = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // Reset state
        #1;
        chk("rst_rsp_product", rsp_product, PW'(0));
        chk("rst_rsp_id", PW'(rsp_id), PW'(0));
        chk("rst_inflight", PW'(inflight), PW'(0));
        chk("rst_idle", PW'(idle), PW'(1));
        @(negedge CLK);
        step();

        // Single requester 0: 3*5
        set_req(0, 1'b1, 32'd3, 32'd5);
        step();
        chk("t1_ready", PW'(last_ready), PW'(4'b0001));
        req_valid = '0;
        drain(5);
        chk("t1_product", rsp_product, PW'(15));

        // All four requesting from reset: strict rotation and saturation
        do_reset();
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, W'(i + 1), W'(i + 10));
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_order", PW'(last_gid), PW'(k % 4));
            if (k >= 2) chk("t2_inflight_sat", PW'(inflight), PW'(3));
            if (last_gid >= 0) set_req(last_gid, 1'b1, W'(100 + k), W'(200 + k));
        end
        req_valid = '0;
        drain(5);
        chk("t2_drained", PW'(inflight), PW'(0));

        // Pointer at 1, then rotation among req1/req2/req3
        do_reset();
        set_req(1, 1'b1, 32'd7, 32'd9);
        step();
        chk("t3_g1", PW'(last_ready), PW'(4'b0010));
        set_req(3, 1'b1, 32'd11, 32'd13);
        step();
        chk("t3_g3", PW'(last_ready), PW'(4'b1000));
        req_valid[3] = 1'b0;
        set_req(2, 1'b1, 32'h100, 32'h100);
        step();
        chk("t3_g1b", PW'(last_ready), PW'(4'b0010));
        req_valid[1] = 1'b0;
        step();
        chk("t3_g2", PW'(last_ready), PW'(4'b0100));
        req_valid = '0;
        drain(5);

        // Carry into the upper product half
        set_req(2, 1'b1, 32'h0001_0000, 32'h0001_0000);
        step();
        req_valid = '0;
        drain(5);
        chk("t4_product", rsp_product, 64'h0000_0001_0000_0000);
        chk("t4_id", PW'(rsp_id), PW'(2));

        // Quiet period: operands hold, nothing returns
        drain(3);
        chk("t6_mul_mx_hold", PW'(mul_mx), PW'(32'h0001_0000));
        chk("t6_mul_my_hold", PW'(mul_my), PW'(32'h0001_0000));
        chk("t6_idle", PW'(idle), PW'(1));
        chk("t6_rsp_valid", PW'(rsp_valid), PW'(0));

        // Reset with two ops in flight: both must vanish
        set_req(0, 1'b1, 32'd21, 32'd2);
        set_req(1, 1'b1, 32'd22, 32'd3);
        step();
        req_valid[0] = 1'b0;
        step();
        req_valid = '0;
        chk("t5_pre_inflight", PW'(inflight), PW'(2));
        RST = 1'b0;
        #1;
        chk("t5_async_inflight", PW'(inflight), PW'(0));
        chk("t5_async_rsp_valid", PW'(rsp_valid), PW'(0));
        sb.delete();
        mptr   = IDW'(N - 1);
        exp_mx = '0;
        exp_my = '0;
        @(posedge CLK);
        edge_n++;
        @(negedge CLK);
        RST = 1'b1;
        drain(6);
        chk("t5_idle", PW'(idle), PW'(1));
        chk("t5_inflight", PW'(inflight), PW'(0));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
